// File: rtl/conv_window_controller_if.sv
// Handshake and status bundle between the pixel source / MAC side and the
// convolution window sequencer.
interface conv_window_controller_if #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          shift_en;
  logic          three_shift;
  logic          window_valid;
  logic          out_ready;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          busy;
  logic          done;

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, shift_en, three_shift, window_valid, win_col, win_row, busy, done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, shift_en, three_shift, window_valid, win_col, win_row, busy, done
  );
endinterface

// File: rtl/conv_window_controller.sv
// Sequencer for the convolver's 3-tap window shift register: walks one frame in
// row-major order, drives shift controls and presents complete K x K windows.
module conv_window_controller #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int KERNEL     = 3,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input logic                    clock,
  input logic                    reset,
  conv_window_controller_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d, win_col_q, win_col_d;
  logic [RW-1:0] row_q, row_d, win_row_q, win_row_d;
  logic          win_valid_q, win_valid_d;
  logic          done_q, done_d;
  logic          in_ready_s, accept_s, last_px_s, win_set_s;

  // Handshake qualification for the current pixel
  always_comb begin
    in_ready_s = (state_q == S_STREAM) & (~win_valid_q | bus.out_ready);
    accept_s   = bus.in_valid & in_ready_s;
    last_px_s  = (row_q == ROW_LAST) & (col_q == COL_LAST);
    win_set_s  = accept_s & (row_q >= ROW_MIN) & (col_q >= COL_MIN);
  end

  // Frame state machine and position counters
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          col_d   = '0;
          row_d   = '0;
          state_d = S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (accept_s) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            // Row saturates at the last row; the next start clears it anyway
            if (row_q != ROW_LAST) begin
              row_d = row_q + RW'(1);
            end else begin
              row_d = row_q;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
          if (last_px_s) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (~win_valid_q | bus.out_ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Window flag: a new qualifying pixel wins over a same-cycle consume
  always_comb begin
    if (win_set_s) begin
      win_valid_d = 1'b1;
      win_col_d   = col_q;
      win_row_d   = row_q;
    end else if (win_valid_q & bus.out_ready) begin
      win_valid_d = 1'b0;
      win_col_d   = win_col_q;
      win_row_d   = win_row_q;
    end else begin
      win_valid_d = win_valid_q;
      win_col_d   = win_col_q;
      win_row_d   = win_row_q;
    end
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.shift_en     = accept_s;
  assign bus.three_shift  = accept_s & (col_q == '0) & (row_q != '0);
  assign bus.window_valid = win_valid_q;
  assign bus.win_col      = win_col_q;
  assign bus.win_row      = win_row_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_conv_window_controller.sv
// Randomised scoreboard bench for conv_window_controller on a 4x3 frame with a
// 3x3 kernel; expected windows come from a frame-level reference model.
module tb_conv_window_controller;

  localparam int W = 4;
  localparam int H = 3;
  localparam int K = 3;

  logic clock;
  logic reset;

  conv_window_controller_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  conv_window_controller #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  int exp_row_q[$];
  int exp_col_q[$];
  int pix      = 0;
  int done_cnt = 0;
  bit exp_rise = 1'b0;
  bit exp_fall = 1'b0;
  bit exp_done = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs with the scoreboard every falling edge
  always @(negedge clock) begin
    if (reset) begin
      pix      = 0;
      exp_rise = 1'b0;
      exp_fall = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_rise) check("wv_rise_latency", int'(bus.window_valid), 1);
      if (exp_fall) check("wv_clear", int'(bus.window_valid), 0);
      exp_rise = 1'b0;
      exp_fall = 1'b0;

      if (exp_done) check("done_after_last_window", int'(bus.done), 1);
      else if (bus.done) check("done_spurious", 1, 0);
      exp_done = 1'b0;

      if (!bus.busy) begin
        check("idle_no_shift", int'({bus.in_ready, bus.shift_en}), 0);
        pix = 0;
      end

      if (bus.window_valid) begin
        if (exp_row_q.size() == 0) begin
          check("win_unexpected", 1, 0);
        end else begin
          check("win_row", int'(bus.win_row), exp_row_q[0]);
          check("win_col", int'(bus.win_col), exp_col_q[0]);
        end
        if (!bus.out_ready) check("backpressure_stall", int'({bus.in_ready, bus.shift_en}), 0);
      end

      if (bus.shift_en) begin
        check("shift_needs_valid", int'(bus.in_valid), 1);
        check("three_shift", int'(bus.three_shift), int'((pix % W == 0) && (pix != 0)));
        if ((pix / W >= K - 1) && (pix % W >= K - 1)) exp_rise = 1'b1;
        pix++;
      end else begin
        check("three_shift_no_accept", int'(bus.three_shift), 0);
      end

      if (bus.window_valid && bus.out_ready && exp_row_q.size() > 0) begin
        void'(exp_row_q.pop_front());
        void'(exp_col_q.pop_front());
        if (!exp_rise) exp_fall = 1'b1;
        if (exp_row_q.size() == 0) exp_done = 1'b1;
      end

      if (bus.done) begin
        done_cnt++;
        check("frame_pixels", pix, W * H);
      end
    end
  end

  // mode: 0 basic, 1 bubbles, 2 random, 3 backpressure, 4 reset mid-frame
  task automatic run_frame(input int mode);
    int  k;
    int  d0;
    int  lat;
    int  stall;
    bit  finished;
    bit  aborted;
    bit  bp_started;
    for (int r = K - 1; r < H; r++) begin
      for (int c = K - 1; c < W; c++) begin
        exp_row_q.push_back(r);
        exp_col_q.push_back(c);
      end
    end
    d0 = done_cnt;
    k = 0; lat = 0; stall = 0;
    finished = 1'b0; aborted = 1'b0; bp_started = 1'b0;
    @(posedge clock); #1;
    bus.start     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (!finished && k < 300) begin
      @(posedge clock); #1;
      k++;
      if (done_cnt != d0) begin
        finished = 1'b1;
        lat = k - 1;
        bus.start = 1'b0;
      end else begin
        bus.start = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        case (mode)
          1: begin
            bus.in_valid  = (k % 2 == 1);
            bus.out_ready = 1'b1;
          end
          2: begin
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.out_ready = ($urandom_range(0, 3) != 0);
          end
          3, 4: begin
            bus.in_valid = 1'b1;
            if (bus.window_valid && !bp_started) begin
              bp_started = 1'b1;
              stall = 5;
            end
            if (mode == 4 && bp_started && stall <= 2) begin
              reset = 1'b1;
              @(posedge clock); #1;
              check("rst_busy", int'(bus.busy), 0);
              check("rst_window_valid", int'(bus.window_valid), 0);
              check("rst_in_ready", int'(bus.in_ready), 0);
              check("rst_done", int'(bus.done), 0);
              reset = 1'b0;
              bus.in_valid = 1'b0;
              exp_row_q.delete();
              exp_col_q.delete();
              aborted  = 1'b1;
              finished = 1'b1;
            end else if (stall > 0) begin
              bus.out_ready = 1'b0;
              stall--;
            end else begin
              bus.out_ready = 1'b1;
            end
          end
          default: begin
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
          end
        endcase
      end
    end
    if (!finished) check("frame_timeout", 0, 1);
    if (!aborted && finished) begin
      check("windows_left", exp_row_q.size(), 0);
      check("done_count", done_cnt - d0, 1);
      if (mode == 0) check("frame_cycles", lat + 1, W * H + 3);
      if (mode == 1) check("frame_cycles_bubbles", lat + 1, W * H + 3 + (W * H - 1));
      if (mode == 3) check("frame_cycles_backpressure", lat + 1, W * H + 3 + 5);
    end
    exp_row_q.delete();
    exp_col_q.delete();
  endtask

  // Stimulus sequence
  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_window_valid", int'(bus.window_valid), 0);
    check("reset_win_pos", int'({bus.win_row, bus.win_col}), 0);
    check("reset_handshake", int'({bus.in_ready, bus.shift_en, bus.three_shift}), 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("idle_ignores_in_valid", int'({bus.in_ready, bus.shift_en}), 0);

    run_frame(0);
    run_frame(1);
    run_frame(3);
    run_frame(4);
    run_frame(0);
    for (int i = 0; i < 20; i++) run_frame(2);
    run_frame(0);

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
